dense_preact_mac: RTL and testbench

- Per-neuron pre-activation stage of the dense/GRU layers; sits directly upstream of tansig_approx.
- Accumulates bias plus the dot product of int8 weights and signed fixed-point inputs.
- Applies the 1/256 weight scale and converts the sum to IEEE-754 single precision, which tansig_approx's `in` port consumes.
- Sequential streaming MAC with a start/accumulate/convert/hold state machine and valid/ready handshakes.

---
 rtl/dense_preact_mac.sv | 127 ++++++++++++
 tb/tb_dense_preact_mac.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dense_preact_mac.sv
// Streaming int8-weight MAC for one neuron: bias + sum(x*w), scaled by 2^-(8+IN_FRAC)
// and converted to IEEE-754 single precision for the downstream tansig stage.
module dense_preact_mac #(
    parameter int IN_W    = 16,
    parameter int IN_FRAC = 8,
    parameter int W_W     = 8,
    parameter int ACC_W   = 40,
    parameter int FLOAT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [W_W-1:0]     bias,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic signed [IN_W-1:0]    s_x,
    input  logic signed [W_W-1:0]     s_w,
    input  logic                      s_last,
    output logic [FLOAT_W-1:0]        out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, CONVERT, HOLD} state_t;

    // Weights are int8 with an implied 1/256 scale, on top of the input's fraction bits.
    localparam int W_FRAC = 8;
    localparam int SCALE  = W_FRAC + IN_FRAC;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [FLOAT_W-1:0]       out_q, out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     s_ready_q, s_ready_d;
    logic                     busy_q, busy_d;
    logic signed [IN_W+W_W-1:0] prod;

    // Mantissa is truncated (round toward zero); exponent range never reaches denormal/inf.
    function automatic logic [FLOAT_W-1:0] acc_to_float(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-1:0] mag;
        logic [ACC_W-1:0] norm;
        logic [7:0]       e;
        logic [22:0]      m;
        int               p;
        mag = $unsigned(a);
        if (a[ACC_W-1]) begin
            mag = (~mag) + {{(ACC_W-1){1'b0}}, 1'b1};
        end
        p = 0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) begin
                p = i;
            end
        end
        norm = mag << (ACC_W - 1 - p);
        e    = 8'(127 + p - SCALE);
        m    = 23'(norm >> (ACC_W - 24));
        if (mag == '0) begin
            return '0;
        end
        return {a[ACC_W-1], e, m};
    endfunction

    assign prod = s_x * s_w;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = ACC_W'(bias) <<< IN_FRAC;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (s_valid) begin
                    acc_d = acc_q + ACC_W'(prod);
                    if (s_last) begin
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                out_d       = acc_to_float(acc_q);
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d == ACCUM);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dense_preact_mac.sv
// Directed bench for dense_preact_mac: single-beat vector table plus multi-cycle sequences.
module tb_dense_preact_mac;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [7:0]  bias;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_x;
    logic signed [7:0]  s_w;
    logic               s_last;
    logic [31:0]        out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    int n_total = 0;
    int n_pass  = 0;

    dense_preact_mac dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_w(s_w), .s_last(s_last),
        .out(out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string              name;
        logic signed [7:0]  b;
        logic signed [15:0] x;
        logic signed [7:0]  w;
        logic [31:0]        exp_out;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic signed [7:0] b, input string name);
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
        bias  = '0;
        chk({name, ".s_ready_after_start"}, {31'b0, s_ready}, 32'd1);
    endtask

    task automatic beat(input logic signed [15:0] x, input logic signed [7:0] w, input logic last,
                        input string name);
        int n;
        s_valid = 1'b1;
        s_x     = x;
        s_w     = w;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        if (!s_ready) chk({name, ".beat_timeout"}, 32'd0, 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_x     = '0;
        s_w     = '0;
    endtask

    // Called right after the last beat's edge: out_valid must rise exactly one edge later.
    task automatic expect_result(input logic [31:0] exp, input string name);
        chk({name, ".valid_low_in_convert"}, {31'b0, out_valid}, 32'd0);
        tick();
        chk({name, ".valid_high"}, {31'b0, out_valid}, 32'd1);
        chk({name, ".out"}, out, exp);
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, ".valid_dropped"}, {31'b0, out_valid}, 32'd0);
        chk({name, ".idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{"unit",       8'sd0,   16'sd256,    8'sd1,    32'h3B800000};
        vecs[1] = '{"bias64",     8'sd64,  16'sd0,      8'sd0,    32'h3E800000};
        vecs[2] = '{"extremes",   8'sd0,  -16'sd32768, -8'sd128,  32'h42800000};
        vecs[3] = '{"neg",        8'sd0,   16'sd256,   -8'sd1,    32'hBB800000};
        vecs[4] = '{"clamp8",     8'sd0,   16'sd8192,   8'sd64,   32'h41000000};
        vecs[5] = '{"zero",       8'sd0,   16'sd1234,   8'sd0,    32'h00000000};
        vecs[6] = '{"mant1500",   8'sd0,  -16'sd300,   -8'sd5,    32'h3CBB8000};
        vecs[7] = '{"bias_plus",  8'sd1,  -16'sd32768, -8'sd128,  32'h42800200};

        rst_n = 1'b0; start = 1'b0; bias = '0; s_valid = 1'b0; s_x = '0; s_w = '0;
        s_last = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("reset.out", out, 32'h0);
        chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset.s_ready", {31'b0, s_ready}, 32'd0);
        chk("reset.busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_start(vecs[i].b, vecs[i].name);
            beat(vecs[i].x, vecs[i].w, 1'b1, vecs[i].name);
            expect_result(vecs[i].exp_out, vecs[i].name);
            drain(vecs[i].name);
            tick();
        end

        // Multi-beat with s_valid gaps, then backpressure with an ignored start in HOLD.
        do_start(8'sd0, "multi");
        beat(16'sd256, 8'sd1, 1'b0, "multi");
        tick();
        beat(16'sd256, 8'sd2, 1'b0, "multi");
        tick();
        tick();
        beat(16'sd256, 8'sd3, 1'b0, "multi");
        beat(16'sd256, 8'sd4, 1'b0, "multi");
        tick();
        beat(16'sd256, -8'sd2, 1'b1, "multi");
        expect_result(32'h3D000000, "multi");
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            tick();
            start = 1'b0;
            chk("multi.hold_valid", {31'b0, out_valid}, 32'd1);
            chk("multi.hold_out", out, 32'h3D000000);
            chk("multi.hold_no_ready", {31'b0, s_ready}, 32'd0);
        end
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        chk("multi.drain_valid", {31'b0, out_valid}, 32'd0);
        chk("multi.start_in_hold_ignored", {31'b0, busy}, 32'd0);
        chk("multi.out_kept", out, 32'h3D000000);
        tick();
        chk("multi.still_idle", {31'b0, busy}, 32'd0);

        // Truncation: 2^24 + 3 keeps bit 1, drops bit 0; early out_ready in CONVERT is ignored.
        do_start(8'sd0, "trunc");
        for (int k = 0; k < 4; k++) beat(-16'sd32768, -8'sd128, 1'b0, "trunc");
        beat(16'sd1, 8'sd3, 1'b1, "trunc");
        out_ready = 1'b1;
        chk("trunc.valid_low_in_convert", {31'b0, out_valid}, 32'd0);
        tick();
        out_ready = 1'b0;
        chk("trunc.valid_high", {31'b0, out_valid}, 32'd1);
        chk("trunc.out", out, 32'h43800001);
        tick();
        chk("trunc.early_ready_ignored", {31'b0, out_valid}, 32'd1);
        drain("trunc");

        // Reset mid-ACCUM abandons the neuron and leaves no accumulator residue.
        do_start(8'sd5, "midrst");
        beat(16'sd1000, 8'sd100, 1'b0, "midrst");
        beat(16'sd1000, 8'sd100, 1'b0, "midrst");
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", {31'b0, busy}, 32'd0);
        chk("midrst.s_ready", {31'b0, s_ready}, 32'd0);
        chk("midrst.out", out, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("midrst.no_valid", {31'b0, out_valid}, 32'd0);
        end
        do_start(8'sd0, "after_rst");
        beat(16'sd256, 8'sd1, 1'b1, "after_rst");
        expect_result(32'h3B800000, "after_rst");
        drain("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
